int_sequencer: RTL and testbench

INT_SEQUENCER -- requirements
Module: int_sequencer

---
 rtl/mos6502_pkg.sv | 30 +++
 rtl/sync2.sv | 22 ++
 rtl/int_sequencer.sv | 105 ++++++++++
 tb/tb_int_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mos6502_pkg.sv
// Shared 6502 constants: interrupt type encoding, vector addresses and the BRK opcode.
package mos6502_pkg;

    typedef enum logic [1:0] {
        INT_NONE    = 2'd0,
        INT_RESET   = 2'd1,
        INT_NMI     = 2'd2,
        INT_IRQ_BRK = 2'd3
    } int_type_t;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_SERVICE    = 2'd2
    } seq_state_t;

    localparam logic [15:0] VEC_NMI     = 16'hFFFA;
    localparam logic [15:0] VEC_RESET   = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_BRK = 16'hFFFE;
    localparam logic [7:0]  BRK_OPCODE  = 8'h00;

    function automatic logic [15:0] vector_of(input int_type_t t);
        case (t)
            INT_NMI:     return VEC_NMI;
            INT_IRQ_BRK: return VEC_IRQ_BRK;
            default:     return VEC_RESET;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an active-low asynchronous pin; idles high.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: reset to 1 (the pin's idle level) so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// 6502 interrupt sequencer: picks RESET/NMI/IRQ/BRK at opcode fetch and injects BRK into the decoder.
module int_sequencer
    import mos6502_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi,
    input  logic        irq,
    input  logic        rdy,
    input  logic [7:0]  data_in,
    input  logic        fetch,
    input  logic        i_flag,
    input  logic        int_done,
    output logic [7:0]  insn,
    output logic [1:0]  int_type,
    output logic [15:0] vector_addr,
    output logic        b_flag,
    output logic        int_active
);

    logic       nmi_s;
    logic       irq_s;
    logic       nmi_prev;
    logic       nmi_pending;
    seq_state_t state;

    sync2 u_sync_nmi (.clk(clk), .rst_n(rst_n), .d(nmi), .q(nmi_s));
    sync2 u_sync_irq (.clk(clk), .rst_n(rst_n), .d(irq), .q(irq_s));

    logic nmi_edge;
    logic irq_pending;
    logic nmi_take;

    assign nmi_edge    = nmi_prev & ~nmi_s;
    assign irq_pending = ~irq_s & ~i_flag;
    assign nmi_take    = rdy & fetch & (state == ST_RUN) & nmi_pending;

    // Edge capture runs regardless of rdy or an active sequence; a fresh edge beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev    <= 1'b1;
            nmi_pending <= 1'b0;
        end else begin
            nmi_prev    <= nmi_s;
            nmi_pending <= nmi_edge | (nmi_pending & ~nmi_take);
        end
    end

    // vector_addr/b_flag are only reloaded when an interrupt is taken; they hold across INT_NONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET_WAIT;
            insn        <= BRK_OPCODE;
            int_type    <= INT_RESET;
            vector_addr <= VEC_RESET;
            b_flag      <= 1'b0;
            int_active  <= 1'b0;
        end else if (rdy) begin
            case (state)
                ST_RESET_WAIT: begin
                    if (fetch) begin
                        insn        <= BRK_OPCODE;
                        int_type    <= INT_RESET;
                        vector_addr <= vector_of(INT_RESET);
                        b_flag      <= 1'b0;
                        int_active  <= 1'b1;
                        state       <= ST_SERVICE;
                    end
                end
                ST_RUN: begin
                    if (fetch) begin
                        if (nmi_pending || irq_pending) begin
                            insn        <= BRK_OPCODE;
                            int_type    <= nmi_pending ? INT_NMI : INT_IRQ_BRK;
                            vector_addr <= vector_of(nmi_pending ? INT_NMI : INT_IRQ_BRK);
                            b_flag      <= 1'b0;
                            int_active  <= 1'b1;
                            state       <= ST_SERVICE;
                        end else begin
                            insn <= data_in;
                            if (data_in == BRK_OPCODE) begin
                                int_type    <= INT_IRQ_BRK;
                                vector_addr <= vector_of(INT_IRQ_BRK);
                                b_flag      <= 1'b1;
                                int_active  <= 1'b1;
                                state       <= ST_SERVICE;
                            end else begin
                                int_type <= INT_NONE;
                            end
                        end
                    end
                end
                ST_SERVICE: begin
                    if (int_done) begin
                        int_type   <= INT_NONE;
                        int_active <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                default: state <= ST_RESET_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus randomized traffic against a rule-level model.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi;
    logic        irq;
    logic        rdy;
    logic [7:0]  data_in;
    logic        fetch;
    logic        i_flag;
    logic        int_done;
    logic [7:0]  insn;
    logic [1:0]  int_type;
    logic [15:0] vector_addr;
    logic        b_flag;
    logic        int_active;

    int_sequencer dut (
        .clk(clk), .rst_n(rst_n), .nmi(nmi), .irq(irq), .rdy(rdy),
        .data_in(data_in), .fetch(fetch), .i_flag(i_flag), .int_done(int_done),
        .insn(insn), .int_type(int_type), .vector_addr(vector_addr),
        .b_flag(b_flag), .int_active(int_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: waiting-for-reset / running / servicing, with a sticky NMI request.
    int          m_mode;      // 0 waiting for first fetch, 1 running, 2 servicing
    logic [7:0]  m_insn;
    int          m_type;      // 0 none, 1 reset, 2 nmi, 3 irq/brk
    logic [15:0] m_vec;
    logic        m_b;
    logic        m_active;
    logic        m_nmi_req;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_insn = 8'h00; m_type = 1; m_vec = 16'hFFFC;
        m_b = 1'b0; m_active = 1'b0; m_nmi_req = 1'b0;
    endtask

    task automatic model_take(input int t, input logic b);
        m_insn   = 8'h00;
        m_type   = t;
        m_vec    = (t == 2) ? 16'hFFFA : (t == 1) ? 16'hFFFC : 16'hFFFE;
        m_b      = b;
        m_active = 1'b1;
        m_mode   = 2;
    endtask

    // irq/i_flag are assumed settled through the synchronizer when a fetch is issued.
    task automatic model_clock(input logic f, input logic d, input logic r, input logic [7:0] din);
        if (!r) return;
        if (m_mode == 0) begin
            if (f) model_take(1, 1'b0);
        end else if (m_mode == 1) begin
            if (f) begin
                if (m_nmi_req) begin
                    m_nmi_req = 1'b0;
                    model_take(2, 1'b0);
                end else if (!irq && !i_flag) begin
                    model_take(3, 1'b0);
                end else begin
                    m_insn = din;
                    if (din == 8'h00) model_take(3, 1'b1);
                    else m_type = 0;
                end
            end
        end else if (d) begin
            m_mode = 1; m_active = 1'b0; m_type = 0;
        end
    endtask

    task automatic check_outputs();
        check("insn",        16'(insn),        16'(m_insn));
        check("int_type",    16'(int_type),    16'(m_type));
        check("vector_addr", vector_addr,      m_vec);
        check("b_flag",      16'(b_flag),      16'(m_b));
        check("int_active",  16'(int_active),  16'(m_active));
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step(input logic f, input logic d, input logic r, input logic [7:0] din);
        fetch = f; int_done = d; rdy = r; data_in = din;
        @(posedge clk);
        model_clock(f, d, r, din);
        @(negedge clk);
        check_outputs();
        fetch = 1'b0; int_done = 1'b0; rdy = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            logic r;
            r = ($urandom % 4) != 0;
            step(r ? 1'b0 : 1'($urandom), r ? 1'b0 : 1'($urandom), r, 8'($urandom));
        end
    endtask

    task automatic nmi_pulse(input int low_cycles);
        nmi = 1'b0;
        m_nmi_req = 1'b1;
        idle(low_cycles);
        nmi = 1'b1;
        idle(4);
    endtask

    initial begin
        rst_n = 1'b0; nmi = 1'b1; irq = 1'b1; i_flag = 1'b1;
        rdy = 1'b1; data_in = 8'h00; fetch = 1'b0; int_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();

        rst_n = 1'b1;
        idle(3);

        // Reset sequence, then the first real opcode.
        step(1, 0, 1, 8'hA9);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'hA9);

        // Level IRQ with interrupts enabled, then masked.
        irq = 1'b0; i_flag = 1'b0;
        idle(4);
        step(1, 0, 1, 8'h55);
        step(0, 1, 1, 8'h00);
        i_flag = 1'b1;
        step(1, 0, 1, 8'h55);
        irq = 1'b1;
        idle(4);

        // Software BRK.
        step(1, 0, 1, 8'h00);
        step(0, 1, 1, 8'h00);

        // NMI outranks a simultaneously pending IRQ; IRQ follows.
        irq = 1'b0; i_flag = 1'b0;
        nmi_pulse(3);
        step(1, 0, 1, 8'hEA);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'hEA);
        step(0, 1, 1, 8'h00);
        irq = 1'b1; i_flag = 1'b1;
        idle(4);

        // NMI arriving during a BRK service is taken after int_done.
        step(1, 0, 1, 8'h00);
        nmi_pulse(2);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'h12);
        step(0, 1, 1, 8'h00);

        // NMI edge while stalled: fetches with rdy=0 are ignored.
        nmi = 1'b0;
        m_nmi_req = 1'b1;
        for (int k = 0; k < 3; k++) step(1, 1, 0, 8'h77);
        nmi = 1'b1;
        for (int k = 0; k < 3; k++) step(1, 1, 0, 8'h77);
        step(1, 0, 1, 8'h77);
        step(0, 1, 1, 8'h00);

        // Second NMI edge detected in the very cycle the first one is consumed.
        nmi_pulse(2);
        nmi = 1'b0;
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(1, 0, 1, 8'h66);
        m_nmi_req = 1'b1;
        nmi = 1'b1;
        idle(3);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'h66);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'h33);

        // Randomized traffic.
        for (int op = 0; op < 150; op++) begin
            int kind;
            logic [7:0] din;
            irq    = ($urandom % 3) == 0 ? 1'b0 : 1'b1;
            i_flag = 1'($urandom);
            if (($urandom % 4) == 0) nmi_pulse(2);
            else idle(6);
            kind = $urandom % 3;
            din  = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
            step(kind != 1, kind != 0, ($urandom % 5) != 0, din);
        end

        // Reset in the middle of an NMI service discards a pending NMI.
        irq = 1'b1; i_flag = 1'b1;
        idle(4);
        if (m_mode == 2) step(0, 1, 1, 8'h00);
        nmi_pulse(2);
        step(1, 0, 1, 8'h21);
        nmi_pulse(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        step(1, 0, 1, 8'h44);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'h44);
        check("no_nmi_after_reset", 16'(int_type), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
